// File: rtl/pixel_fetch_ctrl.sv
// Sequences the external address counter through one frame and streams the
// 1-cycle-latency ROM data out through a 2-entry FIFO with valid/ready/last.
module pixel_fetch_ctrl #(
  parameter int PIXELS = 1024,
  parameter int DW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [9:0]    count,
  output logic          clear,
  output logic          keep,
  output logic [9:0]    rom_addr,
  input  logic [DW-1:0] rom_q,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  localparam logic [9:0] LAST_ADDR = 10'(PIXELS - 1);

  state_e        state_q;
  logic          busy_q, done_q;
  logic [1:0]    occ_q, occ_d;
  logic          inflight_q, last_pend_q;
  logic          rd_ptr_q, wr_ptr_q;
  logic [DW-1:0] data_q [2];
  logic [1:0]    last_q;

  logic          pop, push, issue, at_last;
  logic [1:0]    pending;

  assign rom_addr  = count;
  assign at_last   = (count == LAST_ADDR);
  assign pix_valid = (occ_q != 2'd0);
  assign pix_data  = data_q[rd_ptr_q];
  assign pix_last  = pix_valid & last_q[rd_ptr_q];
  assign busy      = busy_q;
  assign done      = done_q;

  assign pop     = pix_valid & pix_ready;
  assign push    = inflight_q;
  // FIFO entries plus the read still in flight must never exceed the 2 slots
  assign pending = occ_q + 2'(inflight_q);
  assign issue   = (state_q == FETCH) &&
                   ((pending < 2'd2) || ((pending == 2'd2) && pop));
  assign occ_d   = occ_q + 2'(push) - 2'(pop);

  always_comb begin
    clear = 1'b1;
    keep  = 1'b0;
    if (state_q == FETCH) begin
      keep  = ~issue;
      clear = issue & at_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= FETCH;
          busy_q  <= 1'b1;
        end
        FETCH: if (issue && at_last) state_q <= DRAIN;
        DRAIN: if ((occ_q == 2'd0) && !inflight_q) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      last_pend_q <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= issue;
      if (issue) last_pend_q <= at_last;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      wr_ptr_q   <= wr_ptr_q ^ push;
    end
  end

  // Payload storage carries no reset; occupancy alone qualifies it
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= rom_q;
      last_q[wr_ptr_q] <= last_pend_q;
    end
  end

endmodule
